regfile_epcstack: RTL and testbench

- Parametrised successor to the CPU register-file block.
- N-read/1-write GPR array with register 0 hardwired to zero, write-through bypass, and syscall operand override.
- Write-data and destination muxing is unchanged from the current datapath.
- Replaces the single EPC register with an EPC stack, so nested interrupts can be taken and returned from in order.
- Sits in the ID/WB stage between the control unit, the ALU result, memory read data and the PC.

---
 rtl/regfile_pkg.sv | 65 ++++++
 rtl/epc_stack.sv | 96 +++++++++
 rtl/regfile_epcstack.sv | 135 +++++++++++++
 tb/tb_regfile_epcstack.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared encodings and defaults for the register file with EPC stack.
// Holds the write-source / write-destination selector codes, the default
// syscall and link register numbers, and the EPC stack operation decoder.
package regfile_pkg;

   // Write-data source selector (in_wsrc)
   typedef enum logic [1:0] {
      WSRC_MEM = 2'b00,   // memory read data
      WSRC_ALU = 2'b01,   // ALU result
      WSRC_PC1 = 2'b10,   // current PC + 1 (link value)
      WSRC_EPC = 2'b11    // EPC stack top, pre-edge value
   } wsrc_e;

   // Write-destination selector (in_wdst); 11 aliases rt
   typedef enum logic [1:0] {
      WDST_RT     = 2'b00,
      WDST_RD     = 2'b01,
      WDST_LINK   = 2'b10,
      WDST_RT_ALT = 2'b11
   } wdst_e;

   // Default register numbers used by the datapath
   localparam int DEF_SYS_RA   = 2;    // $v0, syscall code
   localparam int DEF_SYS_RB   = 4;    // $a0, syscall argument
   localparam int DEF_LINK_REG = 31;   // $ra, link destination

   // Resolved EPC stack action for one cycle
   typedef enum logic [1:0] {
      STK_NONE    = 2'b00,
      STK_PUSH    = 2'b01,
      STK_POP     = 2'b10,
      STK_REPLACE = 2'b11
   } stk_op_e;

   typedef struct packed {
      stk_op_e op;
      logic    ovf;   // push refused because the stack is full
      logic    unf;   // pop refused because the stack is empty
   } stk_dec_t;

   // Turns the raw push/pop requests plus occupancy into one action.
   // A simultaneous push and pop swaps the top entry (return straight into
   // a new interrupt); on an empty stack there is nothing to swap, so it
   // degrades to a plain push.
   function automatic stk_dec_t stk_decode(input logic push,
                                           input logic pop,
                                           input logic empty,
                                           input logic full);
      stk_dec_t d;
      d.op  = STK_NONE;
      d.ovf = 1'b0;
      d.unf = 1'b0;
      if (push && pop) begin
         d.op = empty ? STK_PUSH : STK_REPLACE;
      end else if (push) begin
         if (full) d.ovf = 1'b1;
         else      d.op  = STK_PUSH;
      end else if (pop) begin
         if (empty) d.unf = 1'b1;
         else       d.op  = STK_POP;
      end
      return d;
   endfunction

endpackage

// File: rtl/epc_stack.sv
// Parametrised LIFO of exception return PCs. Supports push, pop and
// replace-top, reports full/empty, and keeps sticky overflow/underflow
// flags that only reset clears. The top reads as zero when empty.
module epc_stack
   import regfile_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        top,
   output logic [$clog2(DEPTH):0]   cnt,
   output logic                     full,
   output logic                     empty,
   output logic                     ovf,
   output logic                     unf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic [PTR_W-1:0]  push_idx;
   logic [PTR_W-1:0]  top_idx;
   stk_dec_t          dec;

   // Slot indices: the next free slot is cnt mod DEPTH, the top sits just
   // below it. When full, cnt mod DEPTH wraps to 0 and top_idx to DEPTH-1.
   assign push_idx = cnt_q[PTR_W-1:0];
   assign top_idx  = push_idx - PTR_W'(1);

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign top   = empty ? '0 : mem_q[top_idx];
   assign cnt   = cnt_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

   assign dec = stk_decode(push, pop, empty, full);

   // Next-state for entries, occupancy and sticky error flags
   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the
      // case below leaves it unassigned, which would infer a latch.
      mem_d = mem_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q | dec.ovf;
      unf_d = unf_q | dec.unf;
      case (dec.op)
         STK_PUSH: begin
            mem_d[push_idx] = din;
            cnt_d           = cnt_q + CNT_W'(1);
         end
         STK_POP: begin
            cnt_d = cnt_q - CNT_W'(1);
         end
         STK_REPLACE: begin
            mem_d[top_idx] = din;
         end
         default: ;
      endcase
   end

   // Occupancy and flags, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      // NOTE: entries are deliberately left out of reset; only slots below
      // cnt are ever observable, and cnt resets to zero, so stale contents
      // can never leak out.
      mem_q <= mem_d;
   end

endmodule

// File: rtl/regfile_epcstack.sv
// N-read / 1-write register file with hardwired-zero register 0,
// same-cycle write-through bypass and syscall operand override, plus an
// EPC stack so nested interrupts return in order. Lives in ID/WB and muxes
// write data from memory, ALU, PC+1 or the EPC top.
module regfile_epcstack
   import regfile_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int NREAD     = 2,
   parameter int EPC_DEPTH = 4,
   parameter int SYS_RA    = DEF_SYS_RA,
   parameter int SYS_RB    = DEF_SYS_RB,
   parameter int LINK_REG  = DEF_LINK_REG
)(
   input  logic                        in_clk,
   input  logic                        in_rst_n,
   input  logic                        in_syscall,
   input  logic [NREAD*ADDR_W-1:0]     in_raddr,
   output logic [NREAD*DATA_W-1:0]     out_rdata,
   input  logic                        in_we,
   input  logic [1:0]                  in_wsrc,
   input  logic [1:0]                  in_wdst,
   input  logic [ADDR_W-1:0]           in_rt,
   input  logic [ADDR_W-1:0]           in_rd,
   input  logic [DATA_W-1:0]           in_memdata,
   input  logic [DATA_W-1:0]           in_alu,
   input  logic [DATA_W-1:0]           in_pcout,
   input  logic                        in_int_take,
   input  logic [DATA_W-1:0]           in_int_pc,
   input  logic                        in_eret,
   output logic [DATA_W-1:0]           out_epc,
   output logic [$clog2(EPC_DEPTH):0]  out_epc_cnt,
   output logic                        out_in_isr,
   output logic                        out_epc_ovf,
   output logic                        out_epc_unf
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] gpr_q [NREG];
   logic [DATA_W-1:0] gpr_d [NREG];

   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              gpr_we;
   logic [ADDR_W-1:0] ea [NREAD];

   logic [DATA_W-1:0] epc_top;
   logic              epc_empty;
   logic              epc_full_unused;   // not needed at this level

   // Destination register select
   always_comb begin
      waddr = in_rt;
      case (wdst_e'(in_wdst))
         WDST_RD:   waddr = in_rd;
         WDST_LINK: waddr = ADDR_W'(LINK_REG);
         default:   waddr = in_rt;
      endcase
   end

   // Write data select; PC+1 wraps at DATA_W, EPC is the pre-edge top
   always_comb begin
      wdata = in_memdata;
      case (wsrc_e'(in_wsrc))
         WSRC_ALU: wdata = in_alu;
         WSRC_PC1: wdata = in_pcout + DATA_W'(1);
         WSRC_EPC: wdata = epc_top;
         default:  wdata = in_memdata;
      endcase
   end

   // A write lands only out of reset and never on register 0; the bypass
   // uses the same qualifier so it always mirrors what will be stored.
   assign gpr_we = in_we && in_rst_n && (waddr != '0);

   // GPR array next state
   always_comb begin
      gpr_d = gpr_q;
      if (gpr_we) gpr_d[waddr] = wdata;
   end

   // GPR array storage, architecturally cleared on reset
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      end else begin
         gpr_q <= gpr_d;
      end
   end

   // Effective read addresses; syscall steers only ports 0 and 1
   always_comb begin
      for (int k = 0; k < NREAD; k++) ea[k] = in_raddr[k*ADDR_W +: ADDR_W];
      if (in_syscall) begin
         ea[0] = ADDR_W'(SYS_RA);
         ea[1] = ADDR_W'(SYS_RB);
      end
   end

   // Read mux: zero register, then same-cycle bypass, then stored value
   always_comb begin
      out_rdata = '0;
      for (int k = 0; k < NREAD; k++) begin
         if (ea[k] == '0)
            out_rdata[k*DATA_W +: DATA_W] = '0;
         else if (gpr_we && (ea[k] == waddr))
            out_rdata[k*DATA_W +: DATA_W] = wdata;
         else
            out_rdata[k*DATA_W +: DATA_W] = gpr_q[ea[k]];
      end
   end

   epc_stack #(
      .DATA_W (DATA_W),
      .DEPTH  (EPC_DEPTH)
   ) u_epc_stack (
      .clk   (in_clk),
      .rst_n (in_rst_n),
      .push  (in_int_take),
      .pop   (in_eret),
      .din   (in_int_pc),
      .top   (epc_top),
      .cnt   (out_epc_cnt),
      .full  (epc_full_unused),
      .empty (epc_empty),
      .ovf   (out_epc_ovf),
      .unf   (out_epc_unf)
   );

   assign out_epc    = epc_top;
   assign out_in_isr = ~epc_empty;

endmodule

// File: tb/tb_regfile_epcstack.sv
// Self-checking bench for regfile_epcstack: directed scenarios followed by
// randomized traffic compared against a behavioural model (plain register
// array plus a queue used as the EPC stack).
module tb_regfile_epcstack;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 5;
   localparam int NREAD     = 3;
   localparam int EPC_DEPTH = 4;
   localparam int CNT_W     = 3;

   logic                      in_clk;
   logic                      in_rst_n;
   logic                      in_syscall;
   logic [NREAD*ADDR_W-1:0]   in_raddr;
   logic [NREAD*DATA_W-1:0]   out_rdata;
   logic                      in_we;
   logic [1:0]                in_wsrc;
   logic [1:0]                in_wdst;
   logic [ADDR_W-1:0]         in_rt;
   logic [ADDR_W-1:0]         in_rd;
   logic [DATA_W-1:0]         in_memdata;
   logic [DATA_W-1:0]         in_alu;
   logic [DATA_W-1:0]         in_pcout;
   logic                      in_int_take;
   logic [DATA_W-1:0]         in_int_pc;
   logic                      in_eret;
   logic [DATA_W-1:0]         out_epc;
   logic [CNT_W-1:0]          out_epc_cnt;
   logic                      out_in_isr;
   logic                      out_epc_ovf;
   logic                      out_epc_unf;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   logic [DATA_W-1:0] m_gpr [32];
   logic [DATA_W-1:0] m_stk [$];
   bit                m_ovf;
   bit                m_unf;

   regfile_epcstack #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .NREAD     (NREAD),
      .EPC_DEPTH (EPC_DEPTH)
   ) dut (
      .in_clk      (in_clk),
      .in_rst_n    (in_rst_n),
      .in_syscall  (in_syscall),
      .in_raddr    (in_raddr),
      .out_rdata   (out_rdata),
      .in_we       (in_we),
      .in_wsrc     (in_wsrc),
      .in_wdst     (in_wdst),
      .in_rt       (in_rt),
      .in_rd       (in_rd),
      .in_memdata  (in_memdata),
      .in_alu      (in_alu),
      .in_pcout    (in_pcout),
      .in_int_take (in_int_take),
      .in_int_pc   (in_int_pc),
      .in_eret     (in_eret),
      .out_epc     (out_epc),
      .out_epc_cnt (out_epc_cnt),
      .out_in_isr  (out_in_isr),
      .out_epc_ovf (out_epc_ovf),
      .out_epc_unf (out_epc_unf)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   // Absolute time limit so the run always ends
   initial begin
      #500000;
      $display("FAIL timeout reached without finishing");
      $fatal(1, "time limit");
   end

   // ---------------- model helpers ----------------
   function automatic logic [DATA_W-1:0] exp_epc();
      return (m_stk.size() == 0) ? '0 : m_stk[m_stk.size()-1];
   endfunction

   function automatic logic [ADDR_W-1:0] exp_waddr();
      if (in_wdst == 2'd1) return in_rd;
      if (in_wdst == 2'd2) return 5'd31;
      return in_rt;
   endfunction

   function automatic logic [DATA_W-1:0] exp_wdata();
      case (in_wsrc)
         2'd0:    return in_memdata;
         2'd1:    return in_alu;
         2'd2:    return in_pcout + 32'd1;
         default: return exp_epc();
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] exp_rdata(input int k);
      logic [ADDR_W-1:0] a;
      a = in_raddr[k*ADDR_W +: ADDR_W];
      if (in_syscall && k == 0) a = 5'd2;
      if (in_syscall && k == 1) a = 5'd4;
      if (a == 0) return '0;
      if (in_we && a == exp_waddr()) return exp_wdata();
      return m_gpr[a];
   endfunction

   function automatic logic [NREAD*DATA_W-1:0] exp_rdata_all();
      return {exp_rdata(2), exp_rdata(1), exp_rdata(0)};
   endfunction

   function automatic logic [DATA_W+CNT_W+2:0] exp_state();
      return {exp_epc(), CNT_W'(m_stk.size()), m_stk.size() != 0, m_ovf, m_unf};
   endfunction

   function automatic logic [DATA_W+CNT_W+2:0] dut_state();
      return {out_epc, out_epc_cnt, out_in_isr, out_epc_ovf, out_epc_unf};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
   endtask

   // Applies the current inputs to the model, then advances one clock
   task automatic tick();
      logic [DATA_W-1:0] wd;
      logic [ADDR_W-1:0] wa;
      if (in_rst_n) begin
         wd = exp_wdata();
         wa = exp_waddr();
         if (in_we && wa != 0) m_gpr[wa] = wd;
         if (in_int_take && in_eret) begin
            if (m_stk.size() == 0) m_stk.push_back(in_int_pc);
            else m_stk[m_stk.size()-1] = in_int_pc;
         end else if (in_int_take) begin
            if (m_stk.size() < EPC_DEPTH) m_stk.push_back(in_int_pc);
            else m_ovf = 1;
         end else if (in_eret) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else m_unf = 1;
         end
      end
      @(posedge in_clk);
      #1;
   endtask

   task automatic drive_idle();
      in_syscall  = 0;
      in_raddr    = '0;
      in_we       = 0;
      in_wsrc     = 2'd0;
      in_wdst     = 2'd0;
      in_rt       = '0;
      in_rd       = '0;
      in_memdata  = '0;
      in_alu      = '0;
      in_pcout    = '0;
      in_int_take = 0;
      in_int_pc   = '0;
      in_eret     = 0;
   endtask

   task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
      in_raddr = {a2, a1, a0};
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive_idle();
      in_rst_n = 0;
      model_reset();
      repeat (2) @(posedge in_clk);
      #1;
      in_rst_n = 1;
      // preload reg 3 and one stack entry
      in_we = 1; in_wdst = 2'd1; in_rd = 5'd3; in_wsrc = 2'd1; in_alu = 32'hDEAD;
      tick();
      drive_idle();
      in_int_take = 1; in_int_pc = 32'h77;
      tick();
      drive_idle();
      set_raddr(5'd3, 5'd0, 5'd0);
      #1;
      checks++;
      if (out_rdata[31:0] !== 32'hDEAD || out_epc !== 32'h77) begin
         failures++;
         $display("FAIL reset_preload rdata0=%h epc=%h exp %h/%h", out_rdata[31:0], out_epc, 32'hDEAD, 32'h77);
      end
      // mid-cycle reset while a write and a push are pending
      in_we = 1; in_wdst = 2'd1; in_rd = 5'd6; in_wsrc = 2'd1; in_alu = 32'hBEEF;
      in_int_take = 1; in_int_pc = 32'h88;
      set_raddr(5'd3, 5'd5, 5'd3);
      #1;
      in_rst_n = 0;
      model_reset();
      #1;
      checks++;
      if (out_rdata !== '0) begin
         failures++;
         $display("FAIL reset_rdata got=%h exp=0", out_rdata);
      end
      checks++;
      if (dut_state() !== '0) begin
         failures++;
         $display("FAIL reset_epc_state epc=%h cnt=%0d isr=%b ovf=%b unf=%b exp all 0",
                  out_epc, out_epc_cnt, out_in_isr, out_epc_ovf, out_epc_unf);
      end
      drive_idle();
      #2;
      in_rst_n = 1;
      tick();
      set_raddr(5'd3, 5'd6, 5'd0);
      #1;
      checks++;
      if (out_rdata !== '0 || out_epc_cnt !== 3'd0) begin
         failures++;
         $display("FAIL reset_discard rdata=%h cnt=%0d exp 0/0", out_rdata, out_epc_cnt);
      end
   endtask

   task automatic test_write_bypass();
      drive_idle();
      in_we = 1; in_wdst = 2'd1; in_rd = 5'd5; in_wsrc = 2'd1; in_alu = 32'h1234;
      set_raddr(5'd5, 5'd0, 5'd0);
      #1;
      checks++;
      if (out_rdata[31:0] !== 32'h1234) begin
         failures++;
         $display("FAIL bypass_same_cycle got=%h exp=%h", out_rdata[31:0], 32'h1234);
      end
      tick();
      in_we = 0;
      #1;
      checks++;
      if (out_rdata[31:0] !== 32'h1234) begin
         failures++;
         $display("FAIL stored_readback got=%h exp=%h", out_rdata[31:0], 32'h1234);
      end
      // write to register 0 is dropped and never bypassed
      in_we = 1; in_rd = 5'd0; in_alu = 32'hFFFF;
      set_raddr(5'd0, 5'd0, 5'd0);
      #1;
      checks++;
      if (out_rdata[31:0] !== 32'h0) begin
         failures++;
         $display("FAIL reg0_bypass got=%h exp=0", out_rdata[31:0]);
      end
      tick();
      in_we = 0;
      #1;
      checks++;
      if (out_rdata[31:0] !== 32'h0) begin
         failures++;
         $display("FAIL reg0_stored got=%h exp=0", out_rdata[31:0]);
      end
   endtask

   task automatic test_syscall();
      logic [4:0]  regs [3] = '{5'd2, 5'd4, 5'd9};
      logic [31:0] vals [3] = '{32'hA, 32'hB, 32'hC};
      drive_idle();
      for (int i = 0; i < 3; i++) begin
         in_we = 1; in_wdst = 2'd0; in_rt = regs[i]; in_wsrc = 2'd0; in_memdata = vals[i];
         tick();
      end
      drive_idle();
      in_syscall = 1;
      set_raddr(5'd7, 5'd8, 5'd9);
      #1;
      checks++;
      if (out_rdata !== {32'hC, 32'hB, 32'hA}) begin
         failures++;
         $display("FAIL syscall_override got=%h exp=%h", out_rdata, {32'hC, 32'hB, 32'hA});
      end
      in_syscall = 0;
      #1;
      checks++;
      if (out_rdata !== {32'hC, 32'h0, 32'h0}) begin
         failures++;
         $display("FAIL syscall_released got=%h exp=%h", out_rdata, {32'hC, 32'h0, 32'h0});
      end
   endtask

   task automatic test_link();
      drive_idle();
      in_we = 1; in_wdst = 2'd2; in_wsrc = 2'd2; in_pcout = 32'h40;
      tick();
      in_we = 0;
      set_raddr(5'd31, 5'd0, 5'd0);
      #1;
      checks++;
      if (out_rdata[31:0] !== 32'h41) begin
         failures++;
         $display("FAIL link_pc1 got=%h exp=%h", out_rdata[31:0], 32'h41);
      end
      in_we = 1; in_pcout = 32'hFFFF_FFFF;
      tick();
      in_we = 0;
      #1;
      checks++;
      if (out_rdata[31:0] !== 32'h0) begin
         failures++;
         $display("FAIL link_wrap got=%h exp=0", out_rdata[31:0]);
      end
   endtask

   task automatic test_nesting();
      logic [31:0] pcs [3] = '{32'h100, 32'h200, 32'h300};
      drive_idle();
      for (int i = 0; i < 3; i++) begin
         in_int_take = 1; in_int_pc = pcs[i];
         tick();
      end
      drive_idle();
      #1;
      checks++;
      if (out_epc_cnt !== 3'd3 || out_epc !== 32'h300 || out_in_isr !== 1'b1) begin
         failures++;
         $display("FAIL nest_push cnt=%0d epc=%h isr=%b exp 3/300/1", out_epc_cnt, out_epc, out_in_isr);
      end
      in_eret = 1;
      tick();
      in_eret = 0;
      #1;
      checks++;
      if (out_epc_cnt !== 3'd2 || out_epc !== 32'h200) begin
         failures++;
         $display("FAIL nest_pop1 cnt=%0d epc=%h exp 2/200", out_epc_cnt, out_epc);
      end
      in_eret = 1;
      tick();
      tick();
      in_eret = 0;
      #1;
      checks++;
      if (out_epc_cnt !== 3'd0 || out_epc !== 32'h0 || out_in_isr !== 1'b0 || out_epc_unf !== 1'b0) begin
         failures++;
         $display("FAIL nest_empty cnt=%0d epc=%h isr=%b unf=%b exp 0/0/0/0",
                  out_epc_cnt, out_epc, out_in_isr, out_epc_unf);
      end
      in_eret = 1;
      tick();
      in_eret = 0;
      #1;
      checks++;
      if (out_epc_unf !== 1'b1 || out_epc_cnt !== 3'd0 || out_epc_ovf !== 1'b0) begin
         failures++;
         $display("FAIL nest_underflow unf=%b cnt=%0d ovf=%b exp 1/0/0", out_epc_unf, out_epc_cnt, out_epc_ovf);
      end
   endtask

   task automatic test_overflow_replace();
      drive_idle();
      for (int i = 1; i <= 4; i++) begin
         in_int_take = 1; in_int_pc = 32'h400 + 32'(i);
         tick();
      end
      in_int_pc = 32'h500;
      tick();
      drive_idle();
      #1;
      checks++;
      if (out_epc_cnt !== 3'd4 || out_epc_ovf !== 1'b1 || out_epc !== 32'h404) begin
         failures++;
         $display("FAIL overflow cnt=%0d ovf=%b epc=%h exp 4/1/404", out_epc_cnt, out_epc_ovf, out_epc);
      end
      // take + eret together, while writing the old top into reg 10
      in_int_take = 1; in_int_pc = 32'h600; in_eret = 1;
      in_we = 1; in_wdst = 2'd1; in_rd = 5'd10; in_wsrc = 2'd3;
      set_raddr(5'd10, 5'd0, 5'd0);
      #1;
      checks++;
      if (out_rdata[31:0] !== 32'h404) begin
         failures++;
         $display("FAIL epc_wsrc_bypass got=%h exp=%h", out_rdata[31:0], 32'h404);
      end
      tick();
      drive_idle();
      set_raddr(5'd10, 5'd0, 5'd0);
      #1;
      checks++;
      if (out_epc !== 32'h600 || out_epc_cnt !== 3'd4 || out_rdata[31:0] !== 32'h404) begin
         failures++;
         $display("FAIL replace epc=%h cnt=%0d reg10=%h exp 600/4/404", out_epc, out_epc_cnt, out_rdata[31:0]);
      end
      // pop while writing EPC into reg 11: the pre-pop top is stored
      in_eret = 1; in_we = 1; in_wdst = 2'd3; in_rt = 5'd11; in_wsrc = 2'd3;
      tick();
      drive_idle();
      set_raddr(5'd11, 5'd0, 5'd0);
      #1;
      checks++;
      if (out_rdata[31:0] !== 32'h600 || out_epc !== 32'h403 || out_epc_cnt !== 3'd3) begin
         failures++;
         $display("FAIL pop_wsrc_epc reg11=%h epc=%h cnt=%0d exp 600/403/3", out_rdata[31:0], out_epc, out_epc_cnt);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int n = 0; n < 400; n++) begin
         in_syscall  = ($urandom_range(0, 5) == 0);
         in_we       = $urandom_range(0, 1);
         in_wsrc     = 2'($urandom_range(0, 3));
         in_wdst     = 2'($urandom_range(0, 3));
         in_rt       = 5'($urandom_range(0, 7));
         in_rd       = 5'($urandom_range(0, 7));
         for (int k = 0; k < NREAD; k++)
            in_raddr[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         in_memdata  = $urandom();
         in_alu      = $urandom();
         in_pcout    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
         in_int_take = ($urandom_range(0, 2) == 0);
         in_eret     = ($urandom_range(0, 2) == 0);
         in_int_pc   = $urandom();
         #1;
         checks++;
         if (out_rdata !== exp_rdata_all()) begin
            failures++;
            bad++;
            if (bad <= 5) $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, out_rdata, exp_rdata_all());
         end
         checks++;
         if (dut_state() !== exp_state()) begin
            failures++;
            bad++;
            if (bad <= 5) $display("FAIL rand_epc n=%0d got=%h exp=%h", n, dut_state(), exp_state());
         end
         tick();
      end
      drive_idle();
      #1;
      checks++;
      if (dut_state() !== exp_state()) begin
         failures++;
         $display("FAIL rand_final_epc got=%h exp=%h", dut_state(), exp_state());
      end
   endtask

   initial begin
      in_rst_n = 0;
      drive_idle();
      test_reset();
      test_write_bypass();
      test_syscall();
      test_link();
      test_nesting();
      test_overflow_replace();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
